// File: rtl/fifo_read_ptr_ctrl_if.sv
// Read-side pointer bus for the async FIFO: pop request, remote write pointer, and read-side status.
interface fifo_read_ptr_ctrl_if #(
  parameter int ADDR_WIDTH = 7
);
  logic                  inc;
  logic [ADDR_WIDTH:0]   wptr_gray;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [ADDR_WIDTH:0]   rptr_gray;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  gray_err;

  modport master (
    output inc, wptr_gray,
    input  raddr, rptr_gray, empty, count, gray_err
  );

  modport slave (
    input  inc, wptr_gray,
    output raddr, rptr_gray, empty, count, gray_err
  );
endinterface

// File: rtl/fifo_read_ptr_ctrl.sv
// Async FIFO read-pointer controller: write-pointer sync, read counter, empty flag and occupancy.
// Optional sticky illegal-Gray-step checker on the synced write pointer: define GRAY_ERR_CHK_EN.
module fifo_read_ptr_ctrl #(
  parameter int ADDR_WIDTH = 7
) (
  input logic                 clk,
  input logic                 reset,
  fifo_read_ptr_ctrl_if.slave bus
);
  localparam int PW = ADDR_WIDTH + 1;

  logic [PW-1:0] wq1_q, wq2_q;
  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rgray_q, rgray_d;
  logic [PW-1:0] count_q, count_d;
  logic [PW-1:0] wbin_sync;
  logic          empty_q, empty_d;
  logic          pop;

  // Gray-to-binary as the XOR of all right shifts of the code word.
  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int unsigned s = 1; s < PW; s++) begin
      b = b ^ (g >> s);
    end
    return b;
  endfunction

  always_comb begin
    pop       = bus.inc & ~empty_q;
    rbin_d    = rbin_q + PW'(pop);
    rgray_d   = rbin_d ^ (rbin_d >> 1);
    wbin_sync = gray2bin(wq2_q);
    empty_d   = (rgray_d == wq2_q);
    count_d   = wbin_sync - rbin_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wq1_q   <= '0;
      wq2_q   <= '0;
      rbin_q  <= '0;
      rgray_q <= '0;
      count_q <= '0;
      empty_q <= 1'b1;
    end else begin
      wq1_q   <= bus.wptr_gray;
      wq2_q   <= wq1_q;
      rbin_q  <= rbin_d;
      rgray_q <= rgray_d;
      count_q <= count_d;
      empty_q <= empty_d;
    end
  end

  assign bus.raddr     = rbin_q[ADDR_WIDTH-1:0];
  assign bus.rptr_gray = rgray_q;
  assign bus.count     = count_q;
  assign bus.empty     = empty_q;

`ifdef GRAY_ERR_CHK_EN
  logic [PW-1:0] wq2_prev_q;
  logic [PW-1:0] gdiff;
  logic          gray_err_q, gray_err_d;

  // More than one bit set in the step means an illegal Gray transition.
  always_comb begin
    gdiff      = wq2_q ^ wq2_prev_q;
    gray_err_d = gray_err_q | ((gdiff & (gdiff - PW'(1))) != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wq2_prev_q <= '0;
      gray_err_q <= 1'b0;
    end else begin
      wq2_prev_q <= wq2_q;
      gray_err_q <= gray_err_d;
    end
  end

  assign bus.gray_err = gray_err_q;
`else
  assign bus.gray_err = 1'b0;
`endif
endmodule

// File: doc/fifo_read_ptr_ctrl.md
Name: fifo_read_ptr_ctrl

Overview:
Read-side pointer controller for the async FIFO; the consumer of the write-side Gray pointer.
- Brings the remote write Gray pointer into the read clock domain through a 2-flop synchronizer and decodes it to binary.
- Owns the local binary read counter and produces the read address, the Gray read pointer sent back to the write side, the registered empty flag and the occupancy count.

Parameters:
ADDR_WIDTH, 7, FIFO address bits; pointers are ADDR_WIDTH+1 bits (8 by default); depth = 2**ADDR_WIDTH (128).

Ports:
clk  input  1  read-domain clock, rising edge.
reset  input  1  asynchronous, active-high reset.
inc  input  1  pop request from the consumer.
wptr_gray  input  ADDR_WIDTH+1  write pointer (Gray), asynchronous to clk.
raddr  output  ADDR_WIDTH  RAM read address.
rptr_gray  output  ADDR_WIDTH+1  registered Gray read pointer, returned to the write domain.
empty  output  1  registered empty flag.
count  output  ADDR_WIDTH+1  registered occupancy, 0..2**ADDR_WIDTH.
gray_err  output  1  sticky illegal-Gray-transition flag (see Optional Feature).

Behaviour:
- Reset: one clock, `clk`; `reset` is asynchronous and active-high. While asserted, every register clears immediately, regardless of clk:
  - wq1, wq2 = 0
  - rbin = 0, rptr_gray = 0, raddr = 0
  - count = 0, empty = 1, gray_err = 0
- Reset mid-operation discards all in-flight sync state; no recovery sequence is needed.
- Synchronizer: wq1 <= wptr_gray; wq2 <= wq1. No logic between the two flops.
- Pop acceptance: pop = inc & ~empty.
  - inc while empty is ignored: no pointer change, no error.
- rbin_next = rbin + pop, wrapping modulo 2**(ADDR_WIDTH+1).
- Registered updates each rising edge:
  - rbin <= rbin_next
  - rptr_gray <= rbin_next ^ (rbin_next >> 1)
  - empty <= (bin2gray(rbin_next) == wq2)
  - count <= gray2bin(wq2) - rbin_next, modulo 2**(ADDR_WIDTH+1)
- raddr = rbin[ADDR_WIDTH-1:0]. Data for the current raddr is valid while empty = 0.
- gray2bin: b[MSB] = g[MSB]; b[i] = b[i+1] ^ g[i].
- Latency, write pointer change to read side: a wptr_gray change stable before edge N shows in wq1 at N, in wq2 at N+1, and in empty/count at edge N+2 (third edge).
- Latency, pop: a pop accepted at edge N updates raddr, rptr_gray, count and empty at edge N. The last pop sets empty at that same edge.
- Empty is pessimistic: it asserts immediately on the last pop and deasserts only after synchronization.
- Simultaneous pop and wq2 advance in the same cycle: count reflects both (new wptr minus new rptr).
- Wrap: rbin 2**(ADDR_WIDTH+1)-1 -> 0.
  - The MSB differing between pointers distinguishes full from empty.
  - count never exceeds 2**ADDR_WIDTH for a legal write side.

Optional Feature:
Macro GRAY_ERR_CHK_EN.
- Defined:
  - Register wq2_prev <= wq2; it resets to 0.
  - If wq2 differs from wq2_prev in more than one bit, gray_err sets on the next edge and stays set until reset.
  - Pointer, empty and count behaviour is unchanged.
- Not defined: wq2_prev and the checker are not built; gray_err is tied to 0. The port is always present.

Test Plan:
1. Reset mid-operation: rbin = 5, count = 3, then assert reset between clock edges -> raddr = 0, rptr_gray = 0x00, empty = 1, count = 0 immediately; all hold while reset is high.
2. wptr_gray 0x00->0x01, inc = 0 -> empty = 1 for two edges, empty = 0 and count = 1 after the third. Then inc = 1 for one cycle -> raddr 0->1, rptr_gray = 0x01, count = 0, empty = 1 at that same edge.
3. Step wptr_gray through legal Gray codes to binary 128 (0xC0) -> count = 128 after sync. Then 128 consecutive pops -> empty = 1, count = 0, rptr_gray = 0xC0, raddr = 0.
4. Wrap: preload via pops so rbin = 255 (rptr_gray = 0x80) with wptr at binary 1 (0x01), pop twice -> rptr_gray 0x80->0x00->0x01, raddr 127->0->1, empty = 1 after the second pop.
5. inc = 1 held for 10 cycles while empty = 1 and wptr_gray is static -> raddr, rptr_gray and count unchanged, empty stays 1.
6. With GRAY_ERR_CHK_EN: wptr_gray jumps 0x00->0x03 -> gray_err = 1 at the third edge and stays 1 through later legal steps until reset. Without the macro -> gray_err stays 0.
